alu_operand_stage: RTL

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/risc16_pkg.sv | 22 ++
 rtl/fwd_mux.sv | 56 +++++
 rtl/alu_operand_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared datapath defaults and ALU operation encodings.
// Used by the ALU operand stage, its forwarding muxes and the ALU itself.
package risc16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int RA_W_DEF  = 3;
    localparam int OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_SLT = 3'b111
    } alu_op_e;

    // Only arithmetic operations produce a meaningful carry.
    function automatic logic is_carry_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: operand source select for one register read port.
// Ports: i_rs_addr/i_rs_data (register file read), i_ex_* (EX-stage
// producer), i_mem_* (MEM-stage writeback), o_data (selected operand).
// Macro ALU_OPERAND_FWD_EN enables EX/MEM bypassing; without it the
// register file value is used directly.
module fwd_mux
    import risc16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RA_W  = RA_W_DEF
) (
    input  logic [RA_W-1:0]  i_rs_addr,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic             i_ex_wr_en,
    input  logic             i_ex_is_load,
    input  logic [RA_W-1:0]  i_ex_rd,
    input  logic [WIDTH-1:0] i_ex_z,
    input  logic             i_mem_wr_en,
    input  logic [RA_W-1:0]  i_mem_rd,
    input  logic [WIDTH-1:0] i_mem_data,
    output logic [WIDTH-1:0] o_data
);

`ifdef ALU_OPERAND_FWD_EN
    logic w_ex_hit;
    logic w_mem_hit;

    // A load in EX has no data yet; that case is a hazard, not a bypass.
    assign w_ex_hit  = i_ex_wr_en && !i_ex_is_load && (i_ex_rd == i_rs_addr);
    assign w_mem_hit = i_mem_wr_en && (i_mem_rd == i_rs_addr);

    always_comb begin
        o_data = i_rs_data;
        if (i_rs_addr == '0) begin
            o_data = '0;
        end else if (w_ex_hit) begin
            o_data = i_ex_z;
        end else if (w_mem_hit) begin
            o_data = i_mem_data;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{i_ex_wr_en, i_ex_is_load, i_ex_rd, i_ex_z,
                        i_mem_wr_en, i_mem_rd, i_mem_data};

    always_comb begin
        o_data = i_rs_data;
        if (i_rs_addr == '0) begin
            o_data = '0;
        end
    end
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: one-deep decode->ALU pipeline register with operand
// selection, load-use hazard bubbles and the ALU carry flag register.
// Inputs: in_valid, rs1/rs2/rd addresses, rs1/rs2 data, imm/use_imm, op_in,
// EX producer (ex_wr_en, ex_is_load, ex_rd, ex_z), MEM writeback
// (mem_wr_en, mem_rd, mem_data), alu_c_out, stall_in, flush.
// Outputs: Input1, Input2, Operation, rd_out, out_valid, c_in, in_ready,
// hazard. Macro ALU_OPERAND_FWD_EN enables forwarding; when undefined any
// pending EX/MEM write to a used source stalls decode instead.
module alu_operand_stage
    import risc16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RA_W  = RA_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [RA_W-1:0]  rs1_addr,
    input  logic [RA_W-1:0]  rs2_addr,
    input  logic [RA_W-1:0]  rd_addr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] imm,
    input  logic             use_imm,
    input  logic [2:0]       op_in,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic [WIDTH-1:0] ex_z,
    input  logic             mem_wr_en,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             alu_c_out,
    input  logic             stall_in,
    input  logic             flush,
    output logic [WIDTH-1:0] Input1,
    output logic [WIDTH-1:0] Input2,
    output logic [2:0]       Operation,
    output logic [RA_W-1:0]  rd_out,
    output logic             out_valid,
    output logic             c_in,
    output logic             in_ready,
    output logic             hazard
);

    logic [WIDTH-1:0] r_in1;
    logic [WIDTH-1:0] r_in2;
    logic [2:0]       r_op;
    logic [RA_W-1:0]  r_rd;
    logic             r_valid;
    logic             r_carry;

    logic [WIDTH-1:0] w_rs1_sel;
    logic [WIDTH-1:0] w_rs2_sel;
    logic [WIDTH-1:0] w_op2;
    logic             w_rs2_used;
    logic             w_ex_hit;
    logic             w_mem_hit;
    logic             w_hazard;

    fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rs1 (
        .i_rs_addr    (rs1_addr),
        .i_rs_data    (rs1_data),
        .i_ex_wr_en   (ex_wr_en),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_ex_z       (ex_z),
        .i_mem_wr_en  (mem_wr_en),
        .i_mem_rd     (mem_rd),
        .i_mem_data   (mem_data),
        .o_data       (w_rs1_sel)
    );

    fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rs2 (
        .i_rs_addr    (rs2_addr),
        .i_rs_data    (rs2_data),
        .i_ex_wr_en   (ex_wr_en),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_ex_z       (ex_z),
        .i_mem_wr_en  (mem_wr_en),
        .i_mem_rd     (mem_rd),
        .i_mem_data   (mem_data),
        .o_data       (w_rs2_sel)
    );

    // An immediate replaces rs2 entirely, so rs2 cannot cause a hazard.
    assign w_rs2_used = !use_imm;
    assign w_op2      = use_imm ? imm : w_rs2_sel;

`ifdef ALU_OPERAND_FWD_EN
    assign w_ex_hit  = ex_wr_en && ex_is_load && (ex_rd != '0) &&
                       ((ex_rd == rs1_addr) ||
                        (w_rs2_used && (ex_rd == rs2_addr)));
    assign w_mem_hit = 1'b0;
`else
    assign w_ex_hit  = ex_wr_en && (ex_rd != '0) &&
                       ((ex_rd == rs1_addr) ||
                        (w_rs2_used && (ex_rd == rs2_addr)));
    assign w_mem_hit = mem_wr_en && (mem_rd != '0) &&
                       ((mem_rd == rs1_addr) ||
                        (w_rs2_used && (mem_rd == rs2_addr)));
`endif

    assign w_hazard = in_valid && (w_ex_hit || w_mem_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in1   <= '0;
            r_in2   <= '0;
            r_op    <= OP_AND;
            r_rd    <= '0;
            r_valid <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            // Carry belongs to the instruction leaving for EX; a flush of
            // the slot does not cancel it, a stall does hold it.
            if (!stall_in && r_valid && is_carry_op(r_op)) begin
                r_carry <= alu_c_out;
            end
            if (flush) begin
                r_valid <= 1'b0;
            end else if (!stall_in) begin
                if (w_hazard) begin
                    r_valid <= 1'b0;
                    r_op    <= OP_AND;
                end else begin
                    r_valid <= in_valid;
                    r_in1   <= w_rs1_sel;
                    r_in2   <= w_op2;
                    r_op    <= op_in;
                    r_rd    <= rd_addr;
                end
            end
        end
    end

    assign Input1    = r_in1;
    assign Input2    = r_in2;
    assign Operation = r_op;
    assign rd_out    = r_rd;
    assign out_valid = r_valid;
    assign c_in      = r_carry;
    assign hazard    = w_hazard;
    assign in_ready  = !stall_in && !w_hazard;

endmodule
